// File: rtl/ysyx_23060025_wb_arb.sv
// ysyx_23060025_wb_arb: write-port arbiter for the GPR/CSR writeback resource.
// The in-order pipeline (ms) has priority over the multiply/divide unit (mdu);
// a starvation counter forces one mdu grant after STARVE_MAX denied cycles.
// The winning request is registered into one-cycle write pulses.
// Optional feature: define WB_ARB_STATS_EN to add force_cnt_o / mdu_wb_cnt_o.
module ysyx_23060025_wb_arb #(
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ms_valid_i,
  output logic                ms_ready_o,
  input  logic                ms_wd_i,
  input  logic [4:0]          ms_wreg_i,
  input  logic [DATA_LEN-1:0] ms_wdata_i,
  input  logic [2:0]          ms_csr_type_i,
  input  logic [11:0]         ms_csr_waddr_i,
  input  logic [DATA_LEN-1:0] ms_csr_wdata_i,
  input  logic                mdu_valid_i,
  output logic                mdu_ready_o,
  input  logic [4:0]          mdu_wreg_i,
  input  logic [DATA_LEN-1:0] mdu_wdata_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [2:0]          csr_type_o,
  output logic [11:0]         csr_waddr_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                src_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]         force_cnt_o,
  output logic [31:0]         mdu_wb_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  localparam logic [0:0] PRI   = 1'b0;
  localparam logic [0:0] FORCE = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            ms_xfer, mdu_xfer, mdu_denied, force_enter;

  // Handshake: ms_ready_o depends on state only, mdu yields to a valid ms in PRI.
  always_comb begin
    ms_ready_o  = (state_q == PRI);
    mdu_ready_o = (state_q == FORCE) ? 1'b1 : !ms_valid_i;
    ms_xfer     = ms_valid_i & ms_ready_o;
    mdu_xfer    = mdu_valid_i & mdu_ready_o;
    mdu_denied  = mdu_valid_i & !mdu_ready_o;
  end

  // Next state and starvation counter; FORCE lasts exactly one cycle.
  always_comb begin
    state_d     = PRI;
    starve_d    = '0;
    force_enter = 1'b0;
    if (state_q == PRI && mdu_denied) begin
      if (starve_q == CntW'(STARVE_MAX - 1)) begin
        state_d     = FORCE;
        force_enter = 1'b1;
      end else begin
        starve_d = starve_q + CntW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= PRI;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Register the winner into write pulses; unused fields hold their last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_o        <= 1'b0;
      wreg_o      <= '0;
      wdata_o     <= '0;
      csr_type_o  <= '0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      src_o       <= 1'b0;
    end else if (ms_xfer) begin
      wd_o        <= ms_wd_i & (ms_wreg_i != 5'd0);
      wreg_o      <= ms_wreg_i;
      wdata_o     <= ms_wdata_i;
      csr_type_o  <= ms_csr_type_i;
      csr_waddr_o <= ms_csr_waddr_i;
      csr_wdata_o <= ms_csr_wdata_i;
      src_o       <= 1'b0;
    end else if (mdu_xfer) begin
      wd_o        <= (mdu_wreg_i != 5'd0);
      wreg_o      <= mdu_wreg_i;
      wdata_o     <= mdu_wdata_i;
      csr_type_o  <= '0;
      src_o       <= 1'b1;
    end else begin
      wd_o        <= 1'b0;
      csr_type_o  <= '0;
    end
  end

`ifdef WB_ARB_STATS_EN
  // Statistics: FORCE entries and mdu transfers, wrapping modulo 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      force_cnt_o  <= '0;
      mdu_wb_cnt_o <= '0;
    end else begin
      if (force_enter) force_cnt_o <= force_cnt_o + 32'd1;
      if (mdu_xfer)    mdu_wb_cnt_o <= mdu_wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060025_wb_arb.sv
// Self-checking bench for ysyx_23060025_wb_arb: directed scenarios plus random
// traffic against a behavioural model of the arbitration rules.
module tb_ysyx_23060025_wb_arb;
  localparam int DATA_LEN   = 32;
  localparam int STARVE_MAX = 7;

  logic                clock = 1'b0;
  logic                reset;
  logic                ms_valid_i, ms_wd_i, mdu_valid_i;
  logic [4:0]          ms_wreg_i, mdu_wreg_i;
  logic [DATA_LEN-1:0] ms_wdata_i, ms_csr_wdata_i, mdu_wdata_i;
  logic [2:0]          ms_csr_type_i;
  logic [11:0]         ms_csr_waddr_i;
  logic                ms_ready_o, mdu_ready_o, wd_o, src_o;
  logic [4:0]          wreg_o;
  logic [DATA_LEN-1:0] wdata_o, csr_wdata_o;
  logic [2:0]          csr_type_o;
  logic [11:0]         csr_waddr_o;
`ifdef WB_ARB_STATS_EN
  logic [31:0]         force_cnt_o, mdu_wb_cnt_o;
`endif

  ysyx_23060025_wb_arb #(.DATA_LEN(DATA_LEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clock          (clock),
    .reset          (reset),
    .ms_valid_i     (ms_valid_i),
    .ms_ready_o     (ms_ready_o),
    .ms_wd_i        (ms_wd_i),
    .ms_wreg_i      (ms_wreg_i),
    .ms_wdata_i     (ms_wdata_i),
    .ms_csr_type_i  (ms_csr_type_i),
    .ms_csr_waddr_i (ms_csr_waddr_i),
    .ms_csr_wdata_i (ms_csr_wdata_i),
    .mdu_valid_i    (mdu_valid_i),
    .mdu_ready_o    (mdu_ready_o),
    .mdu_wreg_i     (mdu_wreg_i),
    .mdu_wdata_i    (mdu_wdata_i),
    .wd_o           (wd_o),
    .wreg_o         (wreg_o),
    .wdata_o        (wdata_o),
    .csr_type_o     (csr_type_o),
    .csr_waddr_o    (csr_waddr_o),
    .csr_wdata_o    (csr_wdata_o),
    .src_o          (src_o)
`ifdef WB_ARB_STATS_EN
    ,
    .force_cnt_o    (force_cnt_o),
    .mdu_wb_cnt_o   (mdu_wb_cnt_o)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: number of consecutive cycles the current mdu request has been refused.
  // Once it has been refused STARVE_MAX times the next cycle belongs to the mdu.
  int                  denied_run = 0;
  logic                e_wd = 0, e_src = 0;
  logic [4:0]          e_wreg = 0;
  logic [DATA_LEN-1:0] e_wdata = 0, e_csr_wdata = 0;
  logic [2:0]          e_csr_type = 0;
  logic [11:0]         e_csr_waddr = 0;
  longint unsigned     e_force_cnt = 0, e_mdu_cnt = 0;
  logic                last_ms_x = 0, last_mdu_x = 0, obs_mdu_rdy = 0;
  int                  wd_pulses = 0;

  // One clock cycle: check ready and outputs at negedge, advance the model at posedge.
  task automatic cycle();
    logic forced, exp_msr, exp_mdr, ms_x, mdu_x;
    @(negedge clock);
    forced  = (denied_run == STARVE_MAX);
    exp_msr = !forced;
    exp_mdr = forced || !ms_valid_i;
    check("ms_ready", ms_ready_o, exp_msr);
    check("mdu_ready", mdu_ready_o, exp_mdr);
    check("wd", wd_o, e_wd);
    check("csr_type", csr_type_o, e_csr_type);
    check("src", src_o, e_src);
    check("wreg", wreg_o, e_wreg);
    check("wdata", wdata_o, e_wdata);
    check("csr_waddr", csr_waddr_o, e_csr_waddr);
    check("csr_wdata", csr_wdata_o, e_csr_wdata);
`ifdef WB_ARB_STATS_EN
    check("force_cnt", force_cnt_o, e_force_cnt & 64'hFFFF_FFFF);
    check("mdu_wb_cnt", mdu_wb_cnt_o, e_mdu_cnt & 64'hFFFF_FFFF);
`endif
    if (wd_o === 1'b1) wd_pulses++;
    obs_mdu_rdy = mdu_ready_o;
    ms_x  = ms_valid_i && exp_msr;
    mdu_x = mdu_valid_i && exp_mdr;
    @(posedge clock);
    if (reset) begin
      denied_run = 0; e_wd = 0; e_src = 0; e_wreg = 0; e_wdata = 0;
      e_csr_type = 0; e_csr_waddr = 0; e_csr_wdata = 0;
      e_force_cnt = 0; e_mdu_cnt = 0;
      ms_x = 0; mdu_x = 0;
    end else begin
      e_wd = 0;
      e_csr_type = 0;
      if (ms_x) begin
        e_wd = ms_wd_i && (ms_wreg_i != 0);
        e_wreg = ms_wreg_i; e_wdata = ms_wdata_i; e_src = 0;
        e_csr_type = ms_csr_type_i; e_csr_waddr = ms_csr_waddr_i;
        e_csr_wdata = ms_csr_wdata_i;
      end else if (mdu_x) begin
        e_wd = (mdu_wreg_i != 0);
        e_wreg = mdu_wreg_i; e_wdata = mdu_wdata_i; e_src = 1;
        e_mdu_cnt++;
      end
      if (mdu_valid_i && !exp_mdr) begin
        denied_run++;
        if (denied_run == STARVE_MAX) e_force_cnt++;
      end else begin
        denied_run = 0;
      end
    end
    last_ms_x  = ms_x;
    last_mdu_x = mdu_x;
    #1;
  endtask

  task automatic idle_inputs();
    ms_valid_i = 0; ms_wd_i = 0; ms_wreg_i = 0; ms_wdata_i = 0;
    ms_csr_type_i = 0; ms_csr_waddr_i = 0; ms_csr_wdata_i = 0;
    mdu_valid_i = 0; mdu_wreg_i = 0; mdu_wdata_i = 0;
  endtask

  // ms always valid, mdu valid until granted; returns the grant cycle index.
  task automatic starve_run(output int grant_cyc);
    grant_cyc = -1;
    ms_valid_i = 1; ms_wd_i = 1; ms_wreg_i = 5'd3; ms_wdata_i = 32'h55;
    mdu_valid_i = 1; mdu_wreg_i = 5'd9; mdu_wdata_i = 32'hABCD;
    for (int i = 0; i < 3 * STARVE_MAX && grant_cyc < 0; i++) begin
      cycle();
      if (last_mdu_x) begin
        grant_cyc = i;
        mdu_valid_i = 0;
      end
    end
    ms_valid_i = 0;
    cycle();
  endtask

  task automatic drive_rand(input int ms_pct, input int mdu_pct);
    if (!ms_valid_i || last_ms_x) begin
      ms_valid_i     = ($urandom_range(99) < ms_pct);
      ms_wd_i        = $urandom_range(1);
      ms_wreg_i      = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      ms_wdata_i     = $urandom;
      ms_csr_type_i  = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd0;
      ms_csr_waddr_i = 12'($urandom);
      ms_csr_wdata_i = $urandom;
    end
    if (!mdu_valid_i || last_mdu_x) begin
      mdu_valid_i = ($urandom_range(99) < mdu_pct);
      mdu_wreg_i  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      mdu_wdata_i = $urandom;
    end
  endtask

  initial begin
    int g;
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    check("reset_wd", wd_o, 1'b0);
    check("reset_wdata", wdata_o, 0);

    // Pipeline only: four back-to-back writes to x5.
    wd_pulses = 0;
    ms_valid_i = 1; ms_wd_i = 1; ms_wreg_i = 5'd5; ms_wdata_i = 32'h1234;
    repeat (4) cycle();
    ms_valid_i = 0;
    repeat (2) cycle();
    check("ms_pulses", wd_pulses, 4);

    // Idle pipeline: mdu accepted at once.
    mdu_valid_i = 1; mdu_wreg_i = 5'd10; mdu_wdata_i = 32'hDEADBEEF;
    cycle();
    check("mdu_direct_grant", obs_mdu_rdy, 1'b1);
    mdu_valid_i = 0;
    cycle();
    cycle();

    // Starvation: grant in cycle STARVE_MAX.
    starve_run(g);
    check("starve_grant", g, STARVE_MAX);
    cycle();

    // CSR-only write.
    ms_valid_i = 1; ms_wd_i = 0; ms_wreg_i = 5'd7; ms_csr_type_i = 3'b001;
    ms_csr_waddr_i = 12'h305; ms_csr_wdata_i = 32'h8000_0000;
    cycle();
    idle_inputs();
    repeat (2) cycle();

    // mdu write to x0: handshake completes, no GPR pulse.
    wd_pulses = 0;
    mdu_valid_i = 1; mdu_wreg_i = 5'd0; mdu_wdata_i = 32'h77;
    cycle();
    check("x0_handshake", last_mdu_x, 1'b1);
    mdu_valid_i = 0;
    repeat (2) cycle();
    check("x0_no_pulse", wd_pulses, 0);

    // Reset while the starvation run is at 5.
    ms_valid_i = 1; ms_wd_i = 1; ms_wreg_i = 5'd4; ms_wdata_i = 32'h99;
    mdu_valid_i = 1; mdu_wreg_i = 5'd11; mdu_wdata_i = 32'h42;
    repeat (5) cycle();
    check("pre_reset_run", denied_run, 5);
    reset = 1;
    idle_inputs();
    cycle();
    reset = 0;
    cycle();
    check("post_reset_wd", wd_o, 1'b0);
`ifdef WB_ARB_STATS_EN
    check("post_reset_force_cnt", force_cnt_o, 0);
`endif
    starve_run(g);
    check("starve_after_reset", g, STARVE_MAX);

    // Random traffic under varying load.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 500; i++) begin
        drive_rand(p == 0 ? 95 : (p == 1 ? 50 : (p == 2 ? 80 : 20)), 60);
        cycle();
      end
    end
    idle_inputs();
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_23060025_wb_arb.md
# ysyx_23060025_wb_arb

Write-port arbiter for the GPR/CSR writeback resource. Two producers share the single register-file write port: the in-order pipeline (LSU to WB path, "ms") and the long-latency multiply/divide unit ("mdu"). Pipeline writes have priority, and a starvation counter forces an mdu grant. The winner is registered into one-cycle write pulses that drive the regfile and CSR file directly.

## Interface
Parameters:
- DATA_LEN, 32, data width of GPR/CSR write data
- STARVE_MAX, 7, max consecutive denied mdu cycles before forced grant; legal 1..255

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ms_valid_i  in  1  pipeline writeback request
- ms_ready_o  out  1  pipeline request accepted this cycle
- ms_wd_i  in  1  pipeline GPR write enable
- ms_wreg_i  in  5  pipeline GPR index
- ms_wdata_i  in  DATA_LEN  pipeline GPR data
- ms_csr_type_i  in  3  pipeline CSR op type (0 = none)
- ms_csr_waddr_i  in  12  CSR address
- ms_csr_wdata_i  in  DATA_LEN  CSR data
- mdu_valid_i  in  1  mdu result request
- mdu_ready_o  out  1  mdu request accepted this cycle
- mdu_wreg_i  in  5  mdu GPR index
- mdu_wdata_i  in  DATA_LEN  mdu result
- wd_o  out  1  GPR write pulse
- wreg_o  out  5  GPR index
- wdata_o  out  DATA_LEN  GPR data
- csr_type_o  out  3  CSR op type pulse (0 = no write)
- csr_waddr_o  out  12  CSR address
- csr_wdata_o  out  DATA_LEN  CSR data
- src_o  out  1  source of current output: 0 = ms, 1 = mdu

## Operation
- FSM states: PRI (reset state), FORCE.
- PRI: ms_ready_o = 1; mdu_ready_o = !ms_valid_i.
- FORCE: ms_ready_o = 0; mdu_ready_o = 1.
- ms_ready_o depends on state only. No combinational path from mdu inputs to ms_ready_o.
- Transfer = valid & ready. At most one transfer per cycle, by construction.
- Starvation counter, width clog2(STARVE_MAX+1):
  - Increments each cycle with mdu_valid_i & !mdu_ready_o.
  - Clears on mdu transfer or when mdu_valid_i = 0.
- PRI to FORCE: at the edge where the mdu is denied and the counter equals STARVE_MAX-1. The counter clears on that edge.
- FORCE to PRI: unconditionally after one cycle, whether or not the mdu transferred.
- Requesters hold valid and payload stable until their transfer.
- ms transfer: registers ms_wd_i, ms_wreg_i, ms_wdata_i, ms_csr_* and src = 0.
- mdu transfer: registers wd = 1, mdu_wreg_i, mdu_wdata_i, csr_type = 0 and src = 1.
- Writes to x0: wd_o is forced 0 (wreg = 0). The handshake still completes.
- No transfer: wd_o = 0 and csr_type_o = 0. Other outputs hold their last value.
- Ordering and RAW hazards between ms and mdu to the same register are excluded upstream by the scoreboard. The arbiter does not check them.

## Timing
- Latency: a transfer in cycle N produces its outputs in cycle N+1. Each write is a one-cycle pulse.
- Throughput: one write per cycle.
- Worst-case mdu wait with ms continuously valid:
  - Denied for STARVE_MAX cycles.
  - Granted in the FORCE cycle, cycle STARVE_MAX.
  - Output in cycle STARVE_MAX+1.
- An ms request in a FORCE cycle stalls exactly one cycle.
- Reset values: all outputs 0, state PRI, counter 0.
- Reset mid-operation: in-flight requests are dropped and no write pulse is emitted in the cycle after reset.

## Configuration
- WB_ARB_STATS_EN defined: adds output ports force_cnt_o[31:0] (count of FORCE entries) and mdu_wb_cnt_o[31:0] (count of mdu transfers).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: those ports and counters are absent. Arbitration behaviour is identical.

## Test plan
- Pipeline only: ms_valid_i = 1 with wreg 5, data 0x1234, for 4 cycles. Expect 4 consecutive wd_o pulses, each one cycle later, src_o = 0, mdu_ready_o = 0.
- Idle pipeline: mdu_valid_i = 1 with wreg 10, data 0xDEADBEEF, ms_valid_i = 0. Expect mdu_ready_o = 1 the same cycle, then wd_o = 1, wreg_o = 10, src_o = 1 the next cycle.
- Starvation (STARVE_MAX = 7): ms valid every cycle, mdu valid from cycle 0.
  - mdu denied in cycles 0..6.
  - Cycle 7 is FORCE: ms_ready_o = 0 and the mdu transfers.
  - Cycle 8 shows the mdu write.
  - Cycle 8 is back in PRI: ms_ready_o = 1.
- CSR write: ms_csr_type_i = 3'b001, addr 0x305, data 0x80000000, ms_wd_i = 0. Expect csr_type_o = 1, csr_waddr_o = 0x305 and wd_o = 0 for exactly one cycle.
- x0 and reset:
  - mdu write to x0: handshake completes, wd_o stays 0.
  - Reset asserted during a counter value of 5: next cycle all outputs 0, state PRI, counter 0.
  - With WB_ARB_STATS_EN: force_cnt_o = 0 after reset.
